// File: rtl/inst_buffer_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction buffer.
// Entry layout, bus widths, default depth/margin and a small popcount helper.
package inst_buffer_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int INST_BUF_DEPTH = 16;
    localparam int INST_BUF_MARGIN = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } ib_entry_t;

    // number of set bits in a 2-slot mask
    function automatic logic [1:0] ones2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode-facing bundle of the instruction buffer.
// master = fetch + decode side, slave = the buffer itself.
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic              flush;
    logic [1:0]        wr_valid;
    logic [INST_W-1:0] wr_inst0;
    logic [INST_W-1:0] wr_inst1;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [1:0]        issue_en;
    logic [1:0]        rd_valid;
    logic [INST_W-1:0] rd_inst0;
    logic [INST_W-1:0] rd_inst1;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic              instbuffer_full;
    logic              ovf_err;

    modport master (
        output flush, wr_valid, wr_inst0, wr_inst1,
        output wr_addr0, wr_addr1, issue_en,
        input  rd_valid, rd_inst0, rd_inst1,
        input  rd_addr0, rd_addr1, instbuffer_full, ovf_err
    );

    modport slave (
        input  flush, wr_valid, wr_inst0, wr_inst1,
        input  wr_addr0, wr_addr1, issue_en,
        output rd_valid, rd_inst0, rd_inst1,
        output rd_addr0, rd_addr1, instbuffer_full, ovf_err
    );

endinterface

// File: rtl/inst_buffer_mem.sv
// Entry storage: DEPTH x 64b array, two writes to consecutive slots,
// two asynchronous reads at raddr and raddr+1 (both wrap modulo DEPTH).
module inst_buffer_mem
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = INST_BUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      we0,
    input  logic      we1,
    input  logic [AW-1:0] waddr,
    input  ib_entry_t wdata0,
    input  ib_entry_t wdata1,
    input  logic [AW-1:0] raddr,
    output ib_entry_t rdata0,
    output ib_entry_t rdata1
);

    ib_entry_t     mem [DEPTH];
    logic [AW-1:0] waddr1;
    logic [AW-1:0] raddr1;

    assign waddr1 = waddr + AW'(1);
    assign raddr1 = raddr + AW'(1);

    // storage is not reset; validity is tracked by the owner's count
    always_ff @(posedge clk) begin
        if (we0) mem[waddr] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction FIFO: 2-wide push from icache, 2-wide pop
// to dual-issue decode, early full for in-flight fetches, 1-cycle flush.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH       = INST_BUF_DEPTH,
    parameter int FULL_MARGIN = INST_BUF_MARGIN
) (
    input logic       clk,
    input logic       resetn,
    inst_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = AW + 2;
    localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
    localparam logic [FW-1:0] MARGIN_F = FW'(FULL_MARGIN);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf_q;

    logic [1:0]    rd_valid;
    logic [1:0]    npop;
    logic [1:0]    want;
    logic [1:0]    npush;
    logic [FW-1:0] free_now;
    logic [FW-1:0] free;
    logic          we0;
    logic          we1;
    ib_entry_t     wdata0;
    ib_entry_t     wdata1;
    ib_entry_t     rdata0;
    ib_entry_t     rdata1;

    // occupancy status; pops free room for same-cycle pushes, slot 0 first
    always_comb begin
        rd_valid = {count >= CW'(2), count >= CW'(1)};
        npop     = ones2(bus.issue_en & rd_valid);
        want     = ones2(bus.wr_valid);
        free_now = DEPTH_F - FW'(count);
        free     = free_now + FW'(npop);
        npush    = (free >= FW'(want)) ? want : free[1:0];
        we0      = !bus.flush && (npush != 2'd0);
        we1      = !bus.flush && (npush == 2'd2);
    end

    assign wdata0 = '{addr: bus.wr_addr0, inst: bus.wr_inst0};
    assign wdata1 = '{addr: bus.wr_addr1, inst: bus.wr_inst1};

    inst_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .we1    (we1),
        .waddr  (tail),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .raddr  (head),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    // pointer and count update; flush discards all same-cycle traffic
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            head  <= head + AW'(npop);
            tail  <= tail + AW'(npush);
            count <= count + CW'(npush) - CW'(npop);
            ovf_q <= (want != npush);
        end
    end

    assign bus.rd_valid        = rd_valid;
    assign bus.rd_inst0        = rd_valid[0] ? rdata0.inst : '0;
    assign bus.rd_addr0        = rd_valid[0] ? rdata0.addr : '0;
    assign bus.rd_inst1        = rd_valid[1] ? rdata1.inst : '0;
    assign bus.rd_addr1        = rd_valid[1] ? rdata1.addr : '0;
    assign bus.instbuffer_full = free_now < MARGIN_F;
    assign bus.ovf_err         = ovf_q;

    a_wr_enc: assert property (@(posedge clk) disable iff (!resetn)
        bus.wr_valid != 2'b10);
    a_iss_enc: assert property (@(posedge clk) disable iff (!resetn)
        bus.issue_en != 2'b10);

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: the driver pushes accepted entries,
// a negedge monitor compares head slots and pops on issue.
module tb_inst_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_on = 1'b0;
    bit   exp_ovf = 1'b0;
    logic [31:0] pc = 32'h0000_1000;
    logic [31:0] saved;
    ent_t q[$];

    inst_buffer_if bus();

    inst_buffer #(
        .DEPTH       (16),
        .FULL_MARGIN (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one clock of stimulus, then the reference model absorbs the writes
    task automatic cyc(input logic [1:0] wv, input logic [1:0] ie,
                       input logic fl);
        ent_t e [2];
        @(posedge clk);
        #1;
        e[0].addr = pc;
        e[0].inst = ~pc;
        e[1].addr = pc + 32'd4;
        e[1].inst = ~(pc + 32'd4);
        bus.wr_valid = wv;
        bus.wr_addr0 = e[0].addr;
        bus.wr_inst0 = e[0].inst;
        bus.wr_addr1 = e[1].addr;
        bus.wr_inst1 = e[1].inst;
        bus.issue_en = ie;
        bus.flush = fl;
        pc = pc + 32'd4 * (32'(wv[0]) + 32'(wv[1]));
        @(negedge clk);
        #1;
        exp_ovf = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (wv[s]) begin
                    if (q.size() < 16) q.push_back(e[s]);
                    else exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        cyc(2'b00, 2'b00, 1'b0);
    endtask

    // monitor: compare head slots with the scoreboard, retire issued ones
    initial begin : monitor
        int sz;
        int np;
        forever begin
            @(negedge clk);
            if (resetn && mon_on) begin
                sz = q.size();
                chk("rd_valid", 32'(bus.rd_valid),
                    32'({sz >= 2, sz >= 1}));
                chk("full", 32'(bus.instbuffer_full),
                    (16 - sz < 4) ? 32'd1 : 32'd0);
                chk("ovf_err", 32'(bus.ovf_err), 32'(exp_ovf));
                chk("rd_addr0", bus.rd_addr0, sz >= 1 ? q[0].addr : 32'd0);
                chk("rd_inst0", bus.rd_inst0, sz >= 1 ? q[0].inst : 32'd0);
                chk("rd_addr1", bus.rd_addr1, sz >= 2 ? q[1].addr : 32'd0);
                chk("rd_inst1", bus.rd_inst1, sz >= 2 ? q[1].inst : 32'd0);
                if (!bus.flush) begin
                    np = 0;
                    if (bus.issue_en[0] && sz >= 1) np++;
                    if (bus.issue_en[1] && sz >= 2) np++;
                    repeat (np) void'(q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        bus.flush = 1'b0;
        bus.wr_valid = 2'b00;
        bus.wr_inst0 = '0;
        bus.wr_inst1 = '0;
        bus.wr_addr0 = '0;
        bus.wr_addr1 = '0;
        bus.issue_en = 2'b00;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_full", 32'(bus.instbuffer_full), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_err), 32'd0);
        chk("rst_rd_addr0", bus.rd_addr0, 32'd0);
        resetn = 1'b1;
        mon_on = 1'b1;

        // three dual writes
        repeat (3) cyc(2'b11, 2'b00, 1'b0);
        idle();
        chk("t1_rd_valid", 32'(bus.rd_valid), 32'd3);
        chk("t1_rd_addr0", bus.rd_addr0, 32'h0000_1000);
        chk("t1_rd_inst0", bus.rd_inst0, 32'hffff_efff);
        chk("t1_rd_addr1", bus.rd_addr1, 32'h0000_1004);

        // full threshold at 13, drops when count drops
        repeat (3) cyc(2'b11, 2'b00, 1'b0);
        idle();
        chk("t2_full_at12", 32'(bus.instbuffer_full), 32'd0);
        cyc(2'b01, 2'b00, 1'b0);
        idle();
        chk("t2_full_at13", 32'(bus.instbuffer_full), 32'd1);
        cyc(2'b00, 2'b11, 1'b0);
        idle();
        chk("t2_full_at11", 32'(bus.instbuffer_full), 32'd0);

        // overflow at 15 + 2, then full-rate pass-through at 16
        repeat (2) cyc(2'b11, 2'b00, 1'b0);
        idle();
        chk("t3_full_at15", 32'(bus.instbuffer_full), 32'd1);
        cyc(2'b11, 2'b00, 1'b0);
        idle();
        chk("t3_ovf_pulse", 32'(bus.ovf_err), 32'd1);
        chk("t3_rd_valid", 32'(bus.rd_valid), 32'd3);
        cyc(2'b11, 2'b11, 1'b0);
        chk("t3_ovf_gone", 32'(bus.ovf_err), 32'd0);
        idle();
        chk("t3_no_ovf", 32'(bus.ovf_err), 32'd0);
        chk("t3_full_at16", 32'(bus.instbuffer_full), 32'd1);

        // drain, then pop 2 against a single entry
        repeat (8) cyc(2'b00, 2'b11, 1'b0);
        cyc(2'b01, 2'b00, 1'b0);
        cyc(2'b00, 2'b11, 1'b0);
        idle();
        chk("t4_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t4_rd_addr0", bus.rd_addr0, 32'd0);
        saved = pc;
        cyc(2'b01, 2'b00, 1'b0);
        idle();
        chk("t4_head_adv", bus.rd_addr0, saved);
        cyc(2'b00, 2'b01, 1'b0);

        // wrap-around: alternating push/pop of 40 sequential PCs
        pc = 32'hbfc0_0000;
        for (int k = 0; k < 40; k++) begin
            cyc(2'b01, 2'b01, 1'b0);
            if (k >= 1) begin
                chk("t5_rd_valid", 32'(bus.rd_valid), 32'd1);
                chk("t5_rd_addr0", bus.rd_addr0,
                    32'hbfc0_0000 + 32'(4 * (k - 1)));
            end
        end
        cyc(2'b00, 2'b01, 1'b0);

        // flush at 9 with a same-cycle dual write
        repeat (4) cyc(2'b11, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 1'b0);
        cyc(2'b11, 2'b00, 1'b1);
        idle();
        chk("t6_flush_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_flush_full", 32'(bus.instbuffer_full), 32'd0);
        chk("t6_flush_ovf", 32'(bus.ovf_err), 32'd0);

        // asynchronous reset mid-fill
        repeat (7) cyc(2'b11, 2'b00, 1'b0);
        idle();
        chk("t6_full_pre", 32'(bus.instbuffer_full), 32'd1);
        #1;
        mon_on = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_arst_addr0", bus.rd_addr0, 32'd0);
        chk("t6_arst_inst0", bus.rd_inst0, 32'd0);
        chk("t6_arst_full", 32'(bus.instbuffer_full), 32'd0);
        q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
        mon_on = 1'b1;
        saved = pc;
        cyc(2'b11, 2'b00, 1'b0);
        idle();
        chk("t6_post_addr0", bus.rd_addr0, saved);
        chk("t6_post_valid", 32'(bus.rd_valid), 32'd3);
        repeat (2) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
